// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for an NCH-way channel mux: steps a registered select through the
// enabled channels in ascending order and streams each captured sample with its channel tag.
module mux_scan_sequencer #(
    parameter int NCH  = 10,
    parameter int DW   = 16,
    parameter int SELW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            continuous,
    input  logic [NCH-1:0]  ch_en,
    output logic [SELW-1:0] sel,
    input  logic [DW-1:0]   mux_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [SELW-1:0] out_ch,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t          state;
    logic [NCH-1:0]  mask;

    // Lowest set bit of the live enable input, used when (re)latching the mask.
    logic            en_any;
    logic [SELW-1:0] en_low;

    always_comb begin
        en_any = 1'b0;
        en_low = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_en[i]) begin
                en_any = 1'b1;
                en_low = SELW'(i);
            end
        end
    end

    // Next enabled channel strictly above sel; search stops at NCH-1, never wraps.
    logic            nxt_any;
    logic [SELW-1:0] nxt;

    always_comb begin
        nxt_any = 1'b0;
        nxt     = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(sel))) begin
                nxt_any = 1'b1;
                nxt     = SELW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mask      <= '0;
            sel       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (en_any) begin
                            mask  <= ch_en;
                            sel   <= en_low;
                            busy  <= 1'b1;
                            state <= CAPTURE;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                // sel has been stable a full cycle by now, so the mux output is settled.
                CAPTURE: begin
                    out_data  <= mux_data;
                    out_ch    <= sel;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (nxt_any) begin
                            sel   <= nxt;
                            state <= CAPTURE;
                        end else begin
                            done <= 1'b1;
                            if (continuous) begin
                                mask <= ch_en;
                            end
                            if (continuous && en_any) begin
                                sel   <= en_low;
                                state <= CAPTURE;
                            end else begin
                                sel   <= '0;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench for mux_scan_sequencer: expected (channel, data) pairs are queued
// when a sweep is launched and popped as the stream handshakes.
module tb_mux_scan_sequencer;

    localparam int NCH  = 10;
    localparam int DW   = 16;
    localparam int SELW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            continuous;
    logic [NCH-1:0]  ch_en;
    logic [SELW-1:0] sel;
    logic [DW-1:0]   mux_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [SELW-1:0] out_ch;
    logic            busy;
    logic            done;

    int n_pass  = 0;
    int n_total = 0;

    logic [SELW+DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    // Mux model: each channel returns a recognisable per-channel value.
    assign mux_data = 16'hA000 + 16'(sel);

    mux_scan_sequencer #(.NCH(NCH), .DW(DW), .SELW(SELW)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .ch_en(ch_en),
        .sel(sel), .mux_data(mux_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch), .busy(busy), .done(done)
    );

    function automatic logic [SELW+DW-1:0] exp_entry(input int c);
        return {SELW'(c), 16'hA000 + 16'(c)};
    endfunction

    // All sampling and driving happens on the falling edge, away from the active edge.
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; continuous = 1'b0; ch_en = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_total++; if (sel !== 4'd0) $display("FAIL reset_sel got %h exp 0", sel); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (out_data !== 16'h0) $display("FAIL reset_data got %h exp 0", out_data); else n_pass++;
        n_total++; if (out_ch !== 4'd0) $display("FAIL reset_ch got %h exp 0", out_ch); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
    endtask

    task automatic test_full_sweep();
        int cyc, first_hs, last_hs, gap_bad;
        bit seen_done;
        logic [SELW+DW-1:0] e;
        exp_q.delete();
        @(negedge clk);
        ch_en = 10'h3FF; continuous = 1'b0; out_ready = 1'b1; start = 1'b1;
        for (int c = 0; c < 10; c++) exp_q.push_back(exp_entry(c));
        cyc = 0; first_hs = -1; last_hs = -1; gap_bad = 0; seen_done = 1'b0;
        while (!seen_done && cyc < 60) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done) begin
                seen_done = 1'b1;
                n_total++; if (cyc != last_hs + 1) $display("FAIL t1_done_timing got cyc %0d exp %0d", cyc, last_hs + 1); else n_pass++;
            end else if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++; $display("FAIL t1_extra_sample got ch %0d exp none", out_ch);
                end else begin
                    e = exp_q.pop_front();
                    n_total++; if ({out_ch, out_data} !== e) $display("FAIL t1_sample got %h/%h exp %h/%h", out_ch, out_data, e[DW+:SELW], e[DW-1:0]); else n_pass++;
                end
                if (first_hs < 0) first_hs = cyc;
                else if (cyc - last_hs != 2) gap_bad++;
                last_hs = cyc;
            end
        end
        n_total++; if (!seen_done) $display("FAIL t1_timeout got no done exp done"); else n_pass++;
        n_total++; if (first_hs != 2) $display("FAIL t1_latency got %0d exp 2", first_hs); else n_pass++;
        n_total++; if (gap_bad != 0) $display("FAIL t1_throughput got %0d bad gaps exp 0", gap_bad); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL t1_missing got %0d left exp 0", exp_q.size()); else n_pass++;
        n_total++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL t1_idle got busy %b valid %b exp 0 0", busy, out_valid); else n_pass++;
    endtask

    task automatic test_sparse_mask();
        int cyc, hs;
        bit seen_done;
        logic [SELW+DW-1:0] e;
        exp_q.delete();
        @(negedge clk);
        ch_en = 10'b10_0010_0001; continuous = 1'b0; out_ready = 1'b1; start = 1'b1;
        exp_q.push_back(exp_entry(0));
        exp_q.push_back(exp_entry(5));
        exp_q.push_back(exp_entry(9));
        cyc = 0; hs = 0; seen_done = 1'b0;
        while (!seen_done && cyc < 40) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done) seen_done = 1'b1;
            else if (out_valid && out_ready) begin
                hs++;
                if (exp_q.size() == 0) begin
                    n_total++; $display("FAIL t2_extra_sample got ch %0d exp none", out_ch);
                end else begin
                    e = exp_q.pop_front();
                    n_total++; if ({out_ch, out_data} !== e) $display("FAIL t2_sample got %h/%h exp %h/%h", out_ch, out_data, e[DW+:SELW], e[DW-1:0]); else n_pass++;
                end
            end
        end
        n_total++; if (!seen_done) $display("FAIL t2_timeout got no done exp done"); else n_pass++;
        n_total++; if (hs != 3) $display("FAIL t2_handshakes got %0d exp 3", hs); else n_pass++;
    endtask

    task automatic test_empty_mask();
        @(negedge clk);
        ch_en = '0; continuous = 1'b0; out_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_total++; if (done !== 1'b1) $display("FAIL t3_done got %b exp 1", done); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL t3_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL t3_busy got %b exp 0", busy); else n_pass++;
        @(negedge clk);
        n_total++; if (done !== 1'b0) $display("FAIL t3_done_pulse got %b exp 0", done); else n_pass++;
        n_total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL t3_quiet got valid %b busy %b exp 0 0", out_valid, busy); else n_pass++;
    endtask

    task automatic test_backpressure();
        int cyc;
        bit seen_done;
        logic [SELW+DW-1:0] e;
        exp_q.delete();
        @(negedge clk);
        ch_en = 10'h00C; continuous = 1'b0; out_ready = 1'b0; start = 1'b1;
        exp_q.push_back(exp_entry(2));
        exp_q.push_back(exp_entry(3));
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        n_total++; if (!out_valid) $display("FAIL t4_valid_timeout got 0 exp 1"); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_total++; if (out_valid !== 1'b1) $display("FAIL t4_hold_valid got %b exp 1", out_valid); else n_pass++;
            n_total++; if (out_ch !== 4'd2) $display("FAIL t4_hold_ch got %0d exp 2", out_ch); else n_pass++;
            n_total++; if (out_data !== 16'hA002) $display("FAIL t4_hold_data got %h exp a002", out_data); else n_pass++;
            n_total++; if (sel !== 4'd2) $display("FAIL t4_hold_sel got %0d exp 2", sel); else n_pass++;
        end
        out_ready = 1'b1;
        cyc = 0; seen_done = 1'b0;
        // Sample at this edge first: the held beat completes on the next rising edge.
        while (!seen_done && cyc < 20) begin
            if (done) seen_done = 1'b1;
            else if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++; $display("FAIL t4_extra_sample got ch %0d exp none", out_ch);
                end else begin
                    e = exp_q.pop_front();
                    n_total++; if ({out_ch, out_data} !== e) $display("FAIL t4_sample got %h/%h exp %h/%h", out_ch, out_data, e[DW+:SELW], e[DW-1:0]); else n_pass++;
                end
            end
            if (!seen_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        n_total++; if (!seen_done || exp_q.size() != 0) $display("FAIL t4_drain got done %b left %0d exp 1 0", seen_done, exp_q.size()); else n_pass++;
    endtask

    task automatic test_continuous();
        int cyc, hs, n_done, last_hs;
        logic [SELW-1:0] last_ch;
        logic [SELW+DW-1:0] e;
        exp_q.delete();
        @(negedge clk);
        ch_en = 10'h003; continuous = 1'b1; out_ready = 1'b1; start = 1'b1;
        foreach (exp_q[i]) ;
        exp_q.push_back(exp_entry(0));
        exp_q.push_back(exp_entry(1));
        exp_q.push_back(exp_entry(0));
        exp_q.push_back(exp_entry(1));
        exp_q.push_back(exp_entry(2));
        cyc = 0; hs = 0; n_done = 0; last_hs = -10; last_ch = '0;
        while (n_done < 3 && cyc < 80) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done) begin
                n_done++;
                n_total++; if (cyc != last_hs + 1 || (last_ch != 4'd1 && last_ch != 4'd2)) $display("FAIL t5_done_pos got cyc %0d ch %0d exp cyc %0d ch 1or2", cyc, last_ch, last_hs + 1); else n_pass++;
            end
            if (out_valid && out_ready) begin
                hs++;
                last_hs = cyc;
                last_ch = out_ch;
                if (exp_q.size() == 0) begin
                    n_total++; $display("FAIL t5_extra_sample got ch %0d exp none", out_ch);
                end else begin
                    e = exp_q.pop_front();
                    n_total++; if ({out_ch, out_data} !== e) $display("FAIL t5_sample got %h/%h exp %h/%h", out_ch, out_data, e[DW+:SELW], e[DW-1:0]); else n_pass++;
                end
                // Mid second pass: new mask must wait for the wrap.
                if (hs == 3) ch_en = 10'h004;
                if (out_ch == 4'd2) continuous = 1'b0;
            end
        end
        n_total++; if (n_done != 3) $display("FAIL t5_done_count got %0d exp 3", n_done); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL t5_missing got %0d left exp 0", exp_q.size()); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL t5_idle_busy got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid_hold();
        int cyc;
        bit seen_done;
        logic [SELW+DW-1:0] e;
        exp_q.delete();
        @(negedge clk);
        ch_en = 10'h3F0; continuous = 1'b0; out_ready = 1'b0; start = 1'b1;
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        n_total++; if (!out_valid) $display("FAIL t6_valid_timeout got 0 exp 1"); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL t6_ctrl got valid %b busy %b done %b exp 0 0 0", out_valid, busy, done); else n_pass++;
        n_total++; if (sel !== 4'd0 || out_ch !== 4'd0 || out_data !== 16'h0) $display("FAIL t6_data got sel %h ch %h data %h exp 0 0 0", sel, out_ch, out_data); else n_pass++;
        @(negedge clk);
        ch_en = 10'h0A0; out_ready = 1'b1; start = 1'b1;
        exp_q.push_back(exp_entry(5));
        exp_q.push_back(exp_entry(7));
        cyc = 0; seen_done = 1'b0;
        while (!seen_done && cyc < 30) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done) seen_done = 1'b1;
            else if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++; $display("FAIL t6_extra_sample got ch %0d exp none", out_ch);
                end else begin
                    e = exp_q.pop_front();
                    n_total++; if ({out_ch, out_data} !== e) $display("FAIL t6_sample got %h/%h exp %h/%h", out_ch, out_data, e[DW+:SELW], e[DW-1:0]); else n_pass++;
                end
            end
        end
        n_total++; if (!seen_done || exp_q.size() != 0) $display("FAIL t6_drain got done %b left %0d exp 1 0", seen_done, exp_q.size()); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; continuous = 1'b0; ch_en = '0; out_ready = 1'b0;
        test_reset();
        test_full_sweep();
        test_sparse_mask();
        test_empty_mask();
        test_backpressure();
        test_continuous();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
